guard_cond_gen: RTL and testbench
=================================

GUARD_COND_GEN -- requirements
Module: guard_cond_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter IF_STREAM, default 1; 0 means every beat is a complete packet (tlast ignored, treated as 1).
REQ-004 SHALL have parameter FIELD_OFFSET, default 0, LSB index of the match field in the head beat.
REQ-005 SHALL have parameter FIELD_WIDTH, default 16, match field width; FIELD_OFFSET+FIELD_WIDTH <= DATA_WIDTH.
REQ-006 SHALL have parameter COND_DEPTH, default 4, condition token FIFO depth, power of two, >= 2.
REQ-007 Ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset.
REQ-008 Ports: s_axis_tdata/tkeep/tlast/tvalid input DATA_WIDTH/KEEP_WIDTH/1/1, s_axis_tready output 1 -- packet input.
REQ-009 Ports: cfg_value input FIELD_WIDTH, cfg_mask input FIELD_WIDTH, cfg_invert input 1 -- predicate configuration.
REQ-010 Ports: m_axis_tdata/tkeep/tlast/tvalid output DATA_WIDTH/KEEP_WIDTH/1/1, m_axis_tready input 1 -- packet output to the guard stage.
REQ-011 Ports: m_cond_tdata output 1, m_cond_tvalid output 1, m_cond_tready input 1 -- one pass/drop token per packet.
REQ-012 Ports: stat_pkt_count output 32, stat_pass_count output 32 -- statistics.

Function
REQ-013 SHALL run FSM states HEAD (next beat is first beat of packet) and BODY; reset state HEAD.
REQ-014 On head-beat acceptance SHALL compute cond = (((field ^ cfg_value) & cfg_mask) == 0) XOR cfg_invert, field = s_axis_tdata[FIELD_OFFSET +: FIELD_WIDTH]; cfg sampled only at that cycle.
REQ-015 SHALL push exactly one cond token per packet, in the same cycle as head-beat acceptance.
REQ-016 HEAD -> BODY on accepted head beat with effective tlast=0; BODY -> HEAD on accepted beat with effective tlast=1; single-beat packets stay in HEAD.
REQ-017 With IF_STREAM=0, effective tlast SHALL be 1 and m_axis_tkeep all ones.
REQ-018 Data path SHALL be a 2-entry skid buffer: 1-cycle latency, full throughput, no combinational path from m_axis_tready to s_axis_tready.
REQ-019 s_axis_tready in HEAD SHALL require skid space AND cond FIFO not full; in BODY only skid space.
REQ-020 Cond FIFO SHALL present registered output; a token is visible on m_cond no earlier than the head beat on m_axis.
REQ-021 Cond FIFO push and pop in the same cycle while full SHALL NOT be allowed (full blocks head beat); push and pop while non-empty, non-full SHALL keep count unchanged.
REQ-022 Pointers SHALL wrap modulo COND_DEPTH; full/empty from a log2(COND_DEPTH)+1-bit count.
REQ-023 Data and cond tokens SHALL be order-preserving; no beat or token dropped or duplicated.
REQ-024 Output valids SHALL NOT deassert without the matching ready once asserted (AXI-Stream).

Reset
REQ-025 rst_n low SHALL asynchronously force: state HEAD, skid and cond FIFO empty, m_axis_tvalid=0, m_cond_tvalid=0, s_axis_tready=0, counters 0; m_axis_tdata/tkeep/tlast and m_cond_tdata SHALL be 0.
REQ-026 Reset mid-packet SHALL discard partial packet and pending tokens; first beat after release is treated as a head beat.
REQ-027 s_axis_tready SHALL be 0 while rst_n is low and rise no earlier than the first clk edge after release.

Configuration
REQ-028 Macro GUARD_COND_GEN_STATS_EN defined: stat_pkt_count increments per accepted head beat, stat_pass_count per pushed token with cond=1, both saturating at 0xFFFFFFFF.
REQ-029 Macro GUARD_COND_GEN_STATS_EN undefined: stat ports present but constant 0, no counter flops.

Verification
REQ-030 cfg_value=0x0800, mask=0xFFFF, invert=0; 3-beat packet field=0x0800, all readies 1 -> one token 1, 3 beats out 1 cycle delayed, tlast on beat 3.
REQ-031 Same cfg, invert=1; single-beat packet field=0x86DD -> token 1; field=0x0800 -> token 0; FSM stays HEAD.
REQ-032 m_cond_tready=0, COND_DEPTH=4, five 1-beat packets offered -> 4 accepted, s_axis_tready=0 on fifth until one token popped.
REQ-033 m_axis_tready toggled 1/0 every cycle, random s_axis_tvalid, 100 packets -> output data/tokens identical in order to reference model, no valid drop without ready.
REQ-034 rst_n asserted on beat 2 of 4-beat packet -> all valids 0 immediately, next input beat yields a new token.
REQ-035 STATS_EN build, 10 packets with 6 matching -> stat_pkt_count=10, stat_pass_count=6; non-STATS build -> both 0.

Source files
------------

// File: rtl/guard_cond_gen.sv
// Evaluates a masked match predicate on each packet's head beat and emits one pass/drop token per
// packet next to the skid-buffered data stream. Optional statistics: define GUARD_COND_GEN_STATS_EN.
module guard_cond_gen #(
  parameter int DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int IF_STREAM    = 1,
  parameter int FIELD_OFFSET = 0,
  parameter int FIELD_WIDTH  = 16,
  parameter int COND_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [FIELD_WIDTH-1:0] cfg_value,
  input  logic [FIELD_WIDTH-1:0] cfg_mask,
  input  logic                   cfg_invert,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_cond_tdata,
  output logic                   m_cond_tvalid,
  input  logic                   m_cond_tready,
  output logic [31:0]            stat_pkt_count,
  output logic [31:0]            stat_pass_count,
  output logic                   dbg_state_o
);

  localparam int PTR_W  = $clog2(COND_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              rdy_en_q;
  logic [BEAT_W-1:0] out_q, out_d, skid_q, skid_d, in_beat;
  logic              out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic              skid_head_q, skid_head_d;

  logic [COND_DEPTH-1:0] cmem_q, cmem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      ccnt_q, ccnt_d, rel_q, rel_d;

  logic                   eff_last, s_acc, head_acc, cond, cond_full, c_pop, ld_head;
  logic [KEEP_WIDTH-1:0]  eff_keep;
  logic [FIELD_WIDTH-1:0] field;

  assign eff_last = (IF_STREAM != 0) ? s_axis_tlast : 1'b1;
  assign eff_keep = (IF_STREAM != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
  assign in_beat  = {s_axis_tdata, eff_keep, eff_last};

  // Ready is built only from flops so downstream ready never reaches upstream combinationally.
  assign cond_full     = (ccnt_q == CNT_W'(COND_DEPTH));
  assign s_axis_tready = rdy_en_q & ~skid_vld_q & ((state_q == ST_BODY) | ~cond_full);
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  assign head_acc      = s_acc & (state_q == ST_HEAD);

  assign field = s_axis_tdata[FIELD_OFFSET +: FIELD_WIDTH];
  assign cond  = (((field ^ cfg_value) & cfg_mask) == '0) ^ cfg_invert;

  // Valid/ready: a beat or token transfers on a clock edge where both are high; once valid is
  // raised it and its payload hold until that transfer.
  assign m_axis_tdata  = out_q[BEAT_W-1 -: DATA_WIDTH];
  assign m_axis_tkeep  = out_q[KEEP_WIDTH:1];
  assign m_axis_tlast  = out_q[0];
  assign m_axis_tvalid = out_vld_q;

  assign m_cond_tvalid = (rel_q != '0);
  assign m_cond_tdata  = cmem_q[rd_ptr_q];
  assign c_pop         = m_cond_tvalid & m_cond_tready;

  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (s_acc) begin
      state_d = eff_last ? ST_HEAD : ST_BODY;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_head_d = skid_head_q;
    skid_vld_d  = skid_vld_q;
    ld_head     = 1'b0;
    if (m_axis_tready || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
        ld_head    = skid_head_q;
      end else if (s_acc) begin
        out_d     = in_beat;
        out_vld_d = 1'b1;
        ld_head   = head_acc;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (s_acc) begin
      skid_d      = in_beat;
      skid_head_d = head_acc;
      skid_vld_d  = 1'b1;
    end
  end

  // rel counts tokens whose head beat has reached the output register; only those are offered.
  always_comb begin
    cmem_d   = cmem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (head_acc) begin
      cmem_d[wr_ptr_q] = cond;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (c_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    ccnt_d = ccnt_q + CNT_W'(head_acc) - CNT_W'(c_pop);
    rel_d  = rel_q + CNT_W'(ld_head) - CNT_W'(c_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HEAD;
      rdy_en_q    <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_head_q <= 1'b0;
      skid_vld_q  <= 1'b0;
      cmem_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ccnt_q      <= '0;
      rel_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_head_q <= skid_head_d;
      skid_vld_q  <= skid_vld_d;
      cmem_q      <= cmem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ccnt_q      <= ccnt_d;
      rel_q       <= rel_d;
    end
  end

`ifdef GUARD_COND_GEN_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, pass_cnt_q, pass_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    pass_cnt_d = pass_cnt_q;
    if (head_acc && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if (head_acc && cond && (pass_cnt_q != 32'hFFFF_FFFF)) begin
      pass_cnt_d = pass_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= 32'd0;
      pass_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign stat_pkt_count  = pkt_cnt_q;
  assign stat_pass_count = pass_cnt_q;
`else
  assign stat_pkt_count  = 32'd0;
  assign stat_pass_count = 32'd0;
`endif

endmodule

// File: tb/tb_guard_cond_gen.sv
// Bench for guard_cond_gen: vector table plus hand sequences, with a negedge scoreboard monitor.
module tb_guard_cond_gen;

  localparam int BW = 64 + 8 + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [15:0] cfg_value, cfg_mask;
  logic        cfg_invert;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic        m_cond_tdata, m_cond_tvalid, m_cond_tready;
  logic [31:0] stat_pkt_count, stat_pass_count;
  logic        dbg_state;

  guard_cond_gen dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_invert(cfg_invert),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_cond_tdata(m_cond_tdata), .m_cond_tvalid(m_cond_tvalid), .m_cond_tready(m_cond_tready),
    .stat_pkt_count(stat_pkt_count), .stat_pass_count(stat_pass_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] field;
    logic [15:0] value;
    logic [15:0] mask;
    logic        inv;
    int          nb;
    logic        exp;
  } vec_t;

  vec_t          tbl[10];
  logic [BW-1:0] exp_d_q[$];
  logic          exp_c_q[$];
  int            n_tests = 0, n_fail = 0;
  int            m_rdy_mode = 0, c_rdy_mode = 0;
  int            n_tok = 0, n_head = 0, n_pass = 0, heads_popped = 0;
  logic          last_cond = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [BW-1:0] beat, hold_beat;
    logic          in_head = 1'b1, out_head = 1'b1, hold_d = 1'b0, hold_c = 1'b0, hold_cv = 1'b0, c;
    int            shown;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_d_q.delete(); exp_c_q.delete();
        in_head = 1'b1; out_head = 1'b1; hold_d = 1'b0; hold_c = 1'b0;
        n_tok = 0; n_head = 0; n_pass = 0; heads_popped = 0;
      end else begin
        beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (hold_d) chk("data_hold", {m_axis_tvalid, beat}, {1'b1, hold_beat});
        if (hold_c) chk("cond_hold", {m_cond_tvalid, m_cond_tdata}, {1'b1, hold_cv});
        if (m_cond_tvalid && m_cond_tready) begin
          shown = heads_popped + ((m_axis_tvalid && out_head) ? 1 : 0);
          chk("cond_not_early", shown > n_tok, 1);
          chk("cond_q_nonempty", exp_c_q.size() != 0, 1);
          if (exp_c_q.size() != 0) chk("cond_token", m_cond_tdata, exp_c_q.pop_front());
          last_cond = m_cond_tdata;
          n_tok++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          chk("data_q_nonempty", exp_d_q.size() != 0, 1);
          if (exp_d_q.size() != 0) chk("data_beat", beat, exp_d_q.pop_front());
          if (out_head) heads_popped++;
          out_head = m_axis_tlast;
        end
        hold_d = m_axis_tvalid && !m_axis_tready;
        hold_beat = beat;
        hold_c = m_cond_tvalid && !m_cond_tready;
        hold_cv = m_cond_tdata;
        if (s_axis_tvalid && s_axis_tready) begin
          exp_d_q.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tlast});
          if (in_head) begin
            c = (((s_axis_tdata[15:0] ^ cfg_value) & cfg_mask) == 16'h0) ^ cfg_invert;
            exp_c_q.push_back(c);
            n_head++;
            if (c) n_pass++;
          end
          in_head = s_axis_tlast;
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      case (m_rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
      case (c_rdy_mode)
        0:       m_cond_tready = 1'b1;
        1:       m_cond_tready = 1'b0;
        default: m_cond_tready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic watchdog();
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic acc = 1'b0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = s_axis_tready && rst_n;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    chk("beat_accepted", acc, 1);
  endtask

  task automatic send_pkt(input logic [15:0] f, input int nb, input int gap);
    logic [63:0] d;
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      if (b == 0) d[15:0] = f;
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      drive_beat(d, (b == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF, b == nb - 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_d_q.size() != 0 || exp_c_q.size() != 0) && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_done", exp_d_q.size() == 0 && exp_c_q.size() == 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int tok0;
    tbl[0] = '{16'h0800, 16'h0800, 16'hFFFF, 1'b0, 3, 1'b1};
    tbl[1] = '{16'h86DD, 16'h0800, 16'hFFFF, 1'b1, 1, 1'b1};
    tbl[2] = '{16'h0800, 16'h0800, 16'hFFFF, 1'b1, 1, 1'b0};
    tbl[3] = '{16'h1234, 16'h12FF, 16'hFF00, 1'b0, 2, 1'b1};
    tbl[4] = '{16'h1234, 16'h13FF, 16'hFF00, 1'b0, 1, 1'b0};
    tbl[5] = '{16'hABCD, 16'h0000, 16'h0000, 1'b0, 4, 1'b1};
    tbl[6] = '{16'hABCD, 16'h0000, 16'h0000, 1'b1, 2, 1'b0};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1, 1'b1};
    tbl[8] = '{16'hFFFE, 16'hFFFF, 16'h0001, 1'b0, 1, 1'b0};
    tbl[9] = '{16'hFFFE, 16'hFFFF, 16'hFFFE, 1'b0, 5, 1'b1};

    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    cfg_value = 16'h0800; cfg_mask = 16'hFFFF; cfg_invert = 1'b0;
    m_axis_tready = 1'b1; m_cond_tready = 1'b1;
    fork
      monitor();
      ready_driver();
      watchdog();
    join_none

    repeat (3) @(posedge clk); #1;
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_m_valids", {m_axis_tvalid, m_cond_tvalid}, 0);
    chk("rst_m_payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_cond_tdata}, 0);
    chk("rst_stats", {stat_pkt_count, stat_pass_count}, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    #2 chk("ready_before_edge", s_axis_tready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", s_axis_tready, 1);

    // Three-beat matching packet, all readies high: one-cycle latency, tlast on beat 3.
    tok0 = n_tok;
    drive_beat({48'h1111_2222_3333, 16'h0800}, 8'hFF, 1'b0);
    chk("p3_b1_valid", m_axis_tvalid, 1);
    chk("p3_b1_data", m_axis_tdata, {48'h1111_2222_3333, 16'h0800});
    chk("p3_token", {m_cond_tvalid, m_cond_tdata}, 2'b11);
    chk("p3_state_body", dbg_state, 1);
    drive_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    chk("p3_b2", {m_axis_tvalid, m_axis_tdata, m_axis_tlast}, {1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0});
    drive_beat(64'hDEAD_BEEF_0000_0002, 8'h0F, 1'b1);
    chk("p3_b3", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {64'hDEAD_BEEF_0000_0002, 8'h0F, 1'b1});
    chk("p3_state_head", dbg_state, 0);
    drain();
    chk("p3_one_token", n_tok - tok0, 1);

    // Reset during beat 2 of a 4-beat packet.
    drive_beat({48'h0, 16'h1234}, 8'hFF, 1'b0);
    drive_beat(64'h5555, 8'hFF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valids", {m_axis_tvalid, m_cond_tvalid, s_axis_tready}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_value = 16'h0800; cfg_mask = 16'hFFFF; cfg_invert = 1'b0;
    drive_beat({48'h77, 16'h0800}, 8'hFF, 1'b1);
    drain();
    chk("midrst_new_token", {n_tok[7:0], last_cond}, {8'd1, 1'b1});
    chk("midrst_state", dbg_state, 0);

    // Vector table: ten packets, six of them matching.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cfg_value = tbl[i].value; cfg_mask = tbl[i].mask; cfg_invert = tbl[i].inv;
      send_pkt(tbl[i].field, tbl[i].nb, 0);
      drain();
      chk($sformatf("tbl%0d_cond", i), last_cond, tbl[i].exp);
      chk($sformatf("tbl%0d_state", i), dbg_state, 0);
    end
    chk("tbl_tokens", n_tok, 10);
`ifdef GUARD_COND_GEN_STATS_EN
    chk("stat_pkt_10", stat_pkt_count, 10);
    chk("stat_pass_6", stat_pass_count, 6);
`else
    chk("stat_pkt_off", stat_pkt_count, 0);
    chk("stat_pass_off", stat_pass_count, 0);
`endif

    // Stalled token consumer: four heads fill the FIFO, the fifth waits for a pop.
    cfg_value = 16'h0800; cfg_mask = 16'hFFFF; cfg_invert = 1'b0;
    tok0 = n_tok;
    c_rdy_mode = 1;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive_beat({48'hA0 + 48'(i), 16'h0800 + 16'(i)}, 8'hFF, 1'b1);
    s_axis_tdata = {48'hA4, 16'h0800}; s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_blocks_head", s_axis_tready, 0);
    end
    chk("full_cond_pending", m_cond_tvalid, 1);
    c_rdy_mode = 0;
    drive_beat({48'hA4, 16'h0800}, 8'hFF, 1'b1);
    drain();
    chk("full_tokens", n_tok - tok0, 5);

    // Random traffic with downstream ready toggling every cycle.
    m_rdy_mode = 1; c_rdy_mode = 2;
    for (int p = 0; p < 100; p++) begin
      logic [15:0] f;
      cfg_mask = 16'($urandom); cfg_value = 16'($urandom); cfg_invert = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 1) != 0) ? (cfg_value ^ (16'($urandom) & ~cfg_mask)) : 16'($urandom);
      send_pkt(f, $urandom_range(1, 4), 2);
    end
    m_rdy_mode = 0; c_rdy_mode = 0;
    drain();
    chk("rand_tokens", n_tok, n_head);
`ifdef GUARD_COND_GEN_STATS_EN
    chk("stat_pkt_final", stat_pkt_count, n_head);
    chk("stat_pass_final", stat_pass_count, n_pass);
`else
    chk("stat_final_off", {stat_pkt_count, stat_pass_count}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
